demux_router: RTL and testbench
===============================

DEMUX_ROUTER -- requirements
Module: demux_router

Interface
REQ-001 Parameter DW, default 3, data width of every channel.
REQ-002 Parameter SW, default 3, select width.
REQ-003 Parameter ROUTE_RST, default 3'd4, reset value of the programmable route register.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input beat present.
REQ-007 in_ready  output  1  input beat accepted when in_valid and in_ready are both 1.
REQ-008 in_sel  input  SW  destination select.
REQ-009 in_data  input  DW  payload.
REQ-010 cfg_we  input  1  write strobe for the route register.
REQ-011 cfg_route  input  SW  new route value.
REQ-012 out_valid  output  4  per-channel valid; bit k-1 belongs to channel k (k=1..4).
REQ-013 out_ready  input  4  per-channel ready.
REQ-014 out_data1..out_data4  output  DW each  per-channel payload.
REQ-015 drop_cnt  output  8  count of dropped beats.

Function
REQ-016 Decode SHALL use fixed priority: sel==0 -> null; sel==1/2/3 -> channel 1/2/3; sel==route -> channel 4; otherwise drop.
REQ-017 A route value of 0..3 SHALL be shadowed by the constant items, so channel 4 is unreachable while it holds.
REQ-018 Each channel SHALL hold one entry, with states EMPTY and FULL.
REQ-019 EMPTY->FULL on an accepted beat routed to the channel; FULL->EMPTY on out_valid&out_ready with no new beat; FULL->FULL (replace) on drain and accept in the same cycle.
REQ-020 in_ready SHALL be 1 for null and drop beats; for a routed beat it SHALL be 1 when the target is EMPTY or draining this cycle. It is combinational from in_sel, route, channel state and out_ready.
REQ-021 Latency: an accepted beat SHALL appear on out_valid/out_data of its channel on the next clock edge.
REQ-022 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 Null beats SHALL be consumed silently; drop beats SHALL increment drop_cnt, saturating at 255.
REQ-024 cfg_we SHALL load route at the clock edge; a beat accepted in the same cycle SHALL decode against the old route.
REQ-025 A route change SHALL NOT move or discard an entry already held in channel 4.
REQ-026 Channels are independent: a stalled channel SHALL NOT block beats destined for other channels.
REQ-027 No X SHALL propagate: out_data of an EMPTY channel SHALL hold its last value, 0 after reset.

Reset
REQ-028 On rst_n low, without waiting for a clock edge: all channels EMPTY, out_valid=0, out_data*=0, drop_cnt=0, route=ROUTE_RST.
REQ-029 Reset mid-transfer SHALL discard all held entries; the first accept after deassertion follows REQ-016..021.

Structure
REQ-030 Package demux_pkg SHALL hold DW, SW, NCH=4, ROUTE_RST, the channel-state enum {EMPTY, FULL} and the drop_cnt width.
REQ-031 Sub-module demux_slot (one-entry holding register with valid/ready) SHALL be instantiated once per channel.
REQ-032 Decode SHALL be a single combinational block with an explicit default branch.

Verification
REQ-033 After reset, send sel=1,2,3 with data 5,6,7 and all out_ready=1 -> out_valid bits 0,1,2 pulse one cycle after each accept with data 5,6,7; drop_cnt=0.
REQ-034 Hold out_ready[1]=0 and send two sel=2 beats -> the first is held stable, in_ready=0 for the second; a sel=1 beat is still accepted during the stall.
REQ-035 Write route=5 together with a sel=5 beat -> that beat is dropped (drop_cnt=1); the next sel=5 beat reaches channel 4.
REQ-036 Write route=2, then send sel=2 -> the beat goes to channel 2 and channel 4 stays EMPTY.
REQ-037 Send 300 sel=7 beats with route=4 -> drop_cnt saturates at 255 and in_ready stays 1.
REQ-038 Assert rst_n low while channel 3 is FULL and stalled -> out_valid=0 immediately, route=4, drop_cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared widths, reset route and channel-state type for demux_router.
// Holds the default data/select widths, the channel count, the reset value of
// the programmable route register and the width of the drop counter.
package demux_pkg;
    localparam int DW = 3;
    localparam int SW = 3;
    localparam int NCH = 4;
    localparam int DCW = 8;
    localparam logic [SW-1:0] ROUTE_RST = 3'd4;
    typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

// File: rtl/demux_router_if.sv
// demux_router_if: input beat handshake plus the four output channels of demux_router.
// Ports (signals): in_valid/in_ready/in_sel/in_data carry the input beat;
// out_valid/out_ready are per-channel (bit k-1 = channel k); out_data1..4 are
// the channel payloads. master drives beats and out_ready, slave is the router.
interface demux_router_if #(
    parameter int DW = demux_pkg::DW,
    parameter int SW = demux_pkg::SW
);
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_sel;
    logic [DW-1:0] in_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_data1;
    logic [DW-1:0] out_data2;
    logic [DW-1:0] out_data3;
    logic [DW-1:0] out_data4;
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data1, out_data2, out_data3, out_data4
    );
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data1, out_data2, out_data3, out_data4
    );
endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with valid/ready on both sides.
// Ports: clk, rst_n (async active-low); i_in_valid/o_in_ready/i_in_data accept
// a beat; o_out_valid/i_out_ready/o_out_data present the held entry.
module demux_slot #(
    parameter int DW = demux_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data
);
    import demux_pkg::*;
    slot_state_t   r_state;
    slot_state_t   w_next;
    logic [DW-1:0] r_data;
    logic          w_accept;
    // A full slot that is draining this cycle can take a replacement beat.
    assign o_in_ready  = (r_state == EMPTY) || i_out_ready;
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = (r_state == FULL);
    assign o_out_data  = r_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = FULL;
        else if (r_state == FULL && i_out_ready) w_next = EMPTY;
    end
    // Data holds its last value when empty so no X ever leaves the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_data <= '0;
        else if (w_accept) r_data <= i_in_data;
    end
endmodule

// File: rtl/demux_router.sv
// demux_router: routes input beats to four one-entry channels by select value.
// Ports: clk, rst_n (async active-low); cfg_we/cfg_route load the route register
// that selects channel 4; drop_cnt counts dropped beats (saturating);
// bus (slave) carries the input handshake and the four output channels.
module demux_router #(
    parameter int            DW        = demux_pkg::DW,
    parameter int            SW        = demux_pkg::SW,
    parameter logic [SW-1:0] ROUTE_RST = demux_pkg::ROUTE_RST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [SW-1:0]              cfg_route,
    output logic [demux_pkg::DCW-1:0]  drop_cnt,
    demux_router_if.slave              bus
);
    import demux_pkg::*;
    logic [SW-1:0]  r_route;
    logic [DCW-1:0] r_drop;
    logic [NCH-1:0] w_hit;
    logic [NCH-1:0] w_slot_rdy;
    logic [NCH-1:0] w_valid;
    logic           w_drop;
    logic [DW-1:0]  w_data [NCH];
    // Constant selects win over the route register, so routes 0..3 hide channel 4.
    always_comb begin
        w_hit  = '0;
        w_drop = 1'b0;
        case (bus.in_sel)
            SW'(0): w_hit = '0;
            SW'(1), SW'(2), SW'(3): w_hit = NCH'(1) << (bus.in_sel - SW'(1));
            default: begin
                if (bus.in_sel == r_route) w_hit[NCH-1] = 1'b1;
                else                       w_drop = 1'b1;
            end
        endcase
    end
    // Null and drop beats are always taken; routed beats wait on their slot only.
    assign bus.in_ready = ~|w_hit | |(w_hit & w_slot_rdy);
    for (genvar i = 0; i < NCH; i++) begin : g_slot
        demux_slot #(.DW(DW)) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_in_valid  (bus.in_valid && w_hit[i]),
            .o_in_ready  (w_slot_rdy[i]),
            .i_in_data   (bus.in_data),
            .o_out_valid (w_valid[i]),
            .i_out_ready (bus.out_ready[i]),
            .o_out_data  (w_data[i])
        );
    end
    assign bus.out_valid = w_valid;
    assign bus.out_data1 = w_data[0];
    assign bus.out_data2 = w_data[1];
    assign bus.out_data3 = w_data[2];
    assign bus.out_data4 = w_data[3];
    assign drop_cnt      = r_drop;
    // Decode above reads r_route, so a beat in the write cycle sees the old route.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_route <= ROUTE_RST;
            r_drop  <= '0;
        end else begin
            if (cfg_we) r_route <= cfg_route;
            if (bus.in_valid && w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: randomized and directed checks of demux_router against a behavioural model.
module tb_demux_router;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_route = '0;
    logic [7:0] drop_cnt;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         m_full [4];
    logic [2:0] m_data [4];
    int         m_drop;
    logic [2:0] m_route;

    demux_router_if #(.DW(3), .SW(3)) bus ();

    demux_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_route (cfg_route),
        .drop_cnt  (drop_cnt),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // 0 = null, 1..4 = channel, 5 = drop
    function automatic int target(input logic [2:0] sel, input logic [2:0] route);
        if (sel == 0) return 0;
        if (sel <= 3) return int'(sel);
        if (sel == route) return 4;
        return 5;
    endfunction

    function automatic logic [2:0] out_data(input int k);
        case (k)
            0: return bus.out_data1;
            1: return bus.out_data2;
            2: return bus.out_data3;
            default: return bus.out_data4;
        endcase
    endfunction

    task automatic check_outputs();
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) begin
            ev[k] = m_full[k];
            chk($sformatf("data%0d", k + 1), 32'(out_data(k)), 32'(m_data[k]));
        end
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_data[k] = '0;
        end
        m_drop  = 0;
        m_route = 3'd4;
    endtask

    task automatic step(input logic v, input logic [2:0] s, input logic [2:0] d,
                        input logic [3:0] ordy, input logic we, input logic [2:0] rt);
        int t;
        bit rdy;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = ordy;
        cfg_we        = we;
        cfg_route     = rt;
        #1;
        t   = target(s, m_route);
        rdy = (t == 0 || t == 5) ? 1'b1 : (!m_full[t-1] || ordy[t-1]);
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        @(posedge clk);
        for (int k = 0; k < 4; k++) if (m_full[k] && ordy[k]) m_full[k] = 0;
        if (v && rdy && t >= 1 && t <= 4) begin
            m_full[t-1] = 1;
            m_data[t-1] = d;
        end
        if (v && t == 5 && m_drop < 255) m_drop++;
        if (we) m_route = rt;
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        bus.in_valid = 1'b0;
        cfg_we       = 1'b0;
        rst_n        = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        model_reset();
        #1;
        check_outputs();
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        // basic routing, all ready
        step(1, 3'd1, 3'd5, 4'hF, 0, 0);
        step(1, 3'd2, 3'd6, 4'hF, 0, 0);
        step(1, 3'd3, 3'd7, 4'hF, 0, 0);
        step(0, 3'd0, 3'd0, 4'hF, 0, 0);
        // channel 2 stalled; channel 1 still flows
        step(1, 3'd2, 3'd3, 4'b1101, 0, 0);
        step(1, 3'd2, 3'd4, 4'b1101, 0, 0);
        step(1, 3'd1, 3'd2, 4'b1101, 0, 0);
        step(0, 3'd0, 3'd0, 4'hF, 0, 0);
        step(0, 3'd0, 3'd0, 4'hF, 0, 0);
        // route write with a beat in the same cycle decodes against the old route
        step(1, 3'd5, 3'd1, 4'hF, 1, 3'd5);
        step(1, 3'd5, 3'd2, 4'h7, 0, 0);
        // shadowed route leaves channel 4's entry in place
        step(0, 3'd0, 3'd0, 4'h7, 1, 3'd2);
        step(1, 3'd2, 3'd6, 4'h7, 0, 0);
        step(1, 3'd5, 3'd3, 4'h7, 0, 0);
        step(0, 3'd0, 3'd0, 4'hF, 1, 3'd4);
        // saturation
        for (int i = 0; i < 300; i++) step(1, 3'd7, 3'(i), 4'hF, 0, 0);
        // reset while channel 3 is full and stalled
        step(1, 3'd3, 3'd5, 4'b1011, 0, 0);
        step(0, 3'd0, 3'd0, 4'b1011, 0, 0);
        async_reset();
        step(1, 3'd4, 3'd6, 4'h0, 0, 0);
        step(1, 3'd4, 3'd1, 4'h0, 0, 0);
        step(0, 3'd0, 3'd0, 4'hF, 0, 0);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom), 3'($urandom), 4'($urandom),
                 1'($urandom_range(0, 9) == 0), 3'($urandom));
            if (i == 250) async_reset();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
